// File: rtl/sparse_kernel_decoder.sv
// ---------------------------------------------------------------------------
// sparse_kernel_decoder
//
// Holds sparse convolution kernels in two ping-pong banks. Each bank is a
// KERNEL_W*KERNEL_H flag bitmap plus the nonzero weights packed in raster
// order. One bank is loaded while the other is decoded. The decoded bank is
// streamed row-major as (weight, column, row, row nonzero count) under
// valid/ready backpressure, and is also presented as a dense zero-filled
// kernel vector.
//
// Optional feature macro: SPARSE_KERNEL_DENSE_MODE_EN
//   When defined, the input 'mode' is sampled at start. With mode=1 the
//   stream walks every kernel position, zeros included.
//
// Ports:
//   clk, reset (async, active low)
//   write side : wr_flag_vld, wr_flag, wr_wei_vld, wr_wei, wr_done,
//                wr_rdy, wr_err (sticky)
//   control    : start, busy, done (one-cycle pulse)
//   stream     : out_vld, out_rdy, out_wei, out_col, out_row, out_row_cnt,
//                out_row_last, out_last
//   dense view : dense_vld, dense_out
// ---------------------------------------------------------------------------
module sparse_kernel_decoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_W    = 3,
    parameter int KERNEL_H    = 3,
    parameter int INDEX_WIDTH = 4,
    parameter int KERNEL_SIZE = KERNEL_W * KERNEL_H
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_flag_vld,
    input  logic [KERNEL_SIZE-1:0]            wr_flag,
    input  logic                              wr_wei_vld,
    input  logic [DATA_WIDTH-1:0]             wr_wei,
    input  logic                              wr_done,
    output logic                              wr_rdy,
    output logic                              wr_err,
    input  logic                              start,
`ifdef SPARSE_KERNEL_DENSE_MODE_EN
    input  logic                              mode,
`endif
    output logic                              busy,
    output logic                              done,
    output logic                              out_vld,
    input  logic                              out_rdy,
    output logic [DATA_WIDTH-1:0]             out_wei,
    output logic [INDEX_WIDTH-1:0]            out_col,
    output logic [INDEX_WIDTH-1:0]            out_row,
    output logic [INDEX_WIDTH-1:0]            out_row_cnt,
    output logic                              out_row_last,
    output logic                              out_last,
    output logic                              dense_vld,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] dense_out
);

    localparam int PTR_W = $clog2(KERNEL_SIZE + 1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;

    // Bank storage is kept in flops: the dense view needs every weight of
    // the read bank at once.
    logic [KERNEL_SIZE-1:0] flag_reg [2];
    logic [DATA_WIDTH-1:0]  wei_reg  [2][KERNEL_SIZE];
    logic [1:0]             full_reg;
    logic                   wr_ptr_reg;
    logic                   rd_ptr_reg;
    logic [PTR_W-1:0]       wptr_reg;
    logic                   wr_err_reg;

    state_t                 state_reg;
    logic [INDEX_WIDTH-1:0] row_reg;
`ifdef SPARSE_KERNEL_DENSE_MODE_EN
    logic                   mode_reg;
`endif

    function automatic logic [PTR_W-1:0] popcount(input logic [KERNEL_SIZE-1:0] v);
        logic [PTR_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) cnt = cnt + PTR_W'(v[i]);
        return cnt;
    endfunction

    // Lowest set column at or above 'from'; KERNEL_W when there is none.
    function automatic int lowest_set(input logic [KERNEL_W-1:0] bits, input int from);
        int r;
        r = KERNEL_W;
        for (int c = KERNEL_W - 1; c >= 0; c--) if (c >= from && bits[c]) r = c;
        return r;
    endfunction

    // ---------------- write side ----------------
    logic             wr_any;
    logic             fin_clear;
    logic [PTR_W-1:0] slot;
    logic [PTR_W-1:0] slot_lim;
    logic             wei_ok;

    assign wr_rdy    = ~full_reg[wr_ptr_reg];
    assign wr_err    = wr_err_reg;
    assign wr_any    = wr_flag_vld | wr_wei_vld | wr_done;
    assign fin_clear = (state_reg == FIN);
    // A flag load in the same cycle restarts the slot count against the new bitmap.
    assign slot      = wr_flag_vld ? '0 : wptr_reg;
    assign slot_lim  = wr_flag_vld ? popcount(wr_flag) : popcount(flag_reg[wr_ptr_reg]);
    assign wei_ok    = (slot < slot_lim);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                flag_reg[b] <= '0;
                for (int k = 0; k < KERNEL_SIZE; k++) wei_reg[b][k] <= '0;
            end
            full_reg   <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            wptr_reg   <= '0;
            wr_err_reg <= 1'b0;
        end else begin
            if (wr_any && !wr_rdy) begin
                wr_err_reg <= 1'b1;
            end else begin
                if (wr_flag_vld) begin
                    // Clearing the weights makes any slot never written read as 0.
                    flag_reg[wr_ptr_reg] <= wr_flag;
                    for (int k = 0; k < KERNEL_SIZE; k++) wei_reg[wr_ptr_reg][k] <= '0;
                    wptr_reg <= '0;
                end
                if (wr_wei_vld) begin
                    if (wei_ok) begin
                        wei_reg[wr_ptr_reg][slot] <= wr_wei;
                        wptr_reg <= slot + PTR_W'(1);
                    end else begin
                        wr_err_reg <= 1'b1;
                    end
                end
                if (wr_done) begin
                    full_reg[wr_ptr_reg] <= 1'b1;
                    wr_ptr_reg <= ~wr_ptr_reg;
                    wptr_reg   <= '0;
                end
            end
            // The read bank is always full here, so it is never the bank
            // accepting writes above.
            if (fin_clear) begin
                full_reg[rd_ptr_reg] <= 1'b0;
                flag_reg[rd_ptr_reg] <= '0;
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    // ---------------- dense view ----------------
    logic [KERNEL_SIZE-1:0] rd_flag;
    logic [PTR_W-1:0]       prefix      [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0]  dense_words [KERNEL_SIZE];

    assign rd_flag   = flag_reg[rd_ptr_reg];
    assign dense_vld = full_reg[rd_ptr_reg];

    // prefix[k] = number of set flags below position k = weight slot of k.
    always_comb begin
        logic [PTR_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            prefix[k] = acc;
            acc = acc + PTR_W'(rd_flag[k]);
        end
    end

    generate
        for (genvar gi = 0; gi < KERNEL_SIZE; gi++) begin : g_dense
            assign dense_words[gi] = (dense_vld && rd_flag[gi]) ?
                                     wei_reg[rd_ptr_reg][prefix[gi]] : '0;
            assign dense_out[DATA_WIDTH*gi +: DATA_WIDTH] = dense_words[gi];
        end
    endgenerate

    // ---------------- decode datapath ----------------
    logic [KERNEL_SIZE-1:0] eff_flag;
    logic [KERNEL_W-1:0]    row_bits;
    logic                   later_nz;
    int                     row_cnt;
    int                     load_col;
    logic                   load_row_last;
    logic [DATA_WIDTH-1:0]  load_wei;
    logic                   emit_load;

    always_comb begin
`ifdef SPARSE_KERNEL_DENSE_MODE_EN
        eff_flag = mode_reg ? '1 : rd_flag;
`else
        eff_flag = rd_flag;
`endif
    end

    always_comb begin
        row_bits = '0;
        later_nz = 1'b0;
        row_cnt  = 0;
        for (int r = 0; r < KERNEL_H; r++) begin
            for (int c = 0; c < KERNEL_W; c++) begin
                if (r == int'(row_reg)) row_bits[c] = eff_flag[r*KERNEL_W + c];
                else if (r > int'(row_reg)) later_nz = later_nz | eff_flag[r*KERNEL_W + c];
            end
        end
        for (int c = 0; c < KERNEL_W; c++) if (row_bits[c]) row_cnt++;
        // SCAN starts a row at its first nonzero; EMIT steps past the current column.
        load_col = (state_reg == SCAN) ? lowest_set(row_bits, 0)
                                       : lowest_set(row_bits, int'(out_col) + 1);
        load_row_last = (lowest_set(row_bits, load_col + 1) == KERNEL_W);
        load_wei = '0;
        for (int k = 0; k < KERNEL_SIZE; k++)
            if (k == int'(row_reg) * KERNEL_W + load_col) load_wei = dense_words[k];
        emit_load = ((state_reg == SCAN) && (row_cnt != 0)) ||
                    ((state_reg == EMIT) && out_rdy && !out_row_last);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            row_reg      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            out_vld      <= 1'b0;
            out_wei      <= '0;
            out_col      <= '0;
            out_row      <= '0;
            out_row_cnt  <= '0;
            out_row_last <= 1'b0;
            out_last     <= 1'b0;
`ifdef SPARSE_KERNEL_DENSE_MODE_EN
            mode_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && dense_vld) begin
                        state_reg <= SCAN;
                        row_reg   <= '0;
                        busy      <= 1'b1;
`ifdef SPARSE_KERNEL_DENSE_MODE_EN
                        mode_reg  <= mode;
`endif
                    end
                end
                SCAN: begin
                    if (row_cnt != 0) begin
                        state_reg <= EMIT;
                        out_vld   <= 1'b1;
                    end else if (row_reg == INDEX_WIDTH'(KERNEL_H - 1)) begin
                        state_reg <= FIN;
                        done      <= 1'b1;
                    end else begin
                        row_reg <= row_reg + INDEX_WIDTH'(1);
                    end
                end
                EMIT: begin
                    if (out_rdy) begin
                        if (out_last) begin
                            out_vld   <= 1'b0;
                            state_reg <= FIN;
                            done      <= 1'b1;
                        end else if (out_row_last) begin
                            out_vld   <= 1'b0;
                            state_reg <= SCAN;
                            row_reg   <= row_reg + INDEX_WIDTH'(1);
                        end
                    end
                end
                FIN: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
            if (emit_load) begin
                out_wei      <= load_wei;
                out_col      <= INDEX_WIDTH'(load_col);
                out_row      <= row_reg;
                out_row_cnt  <= INDEX_WIDTH'(row_cnt);
                out_row_last <= load_row_last;
                out_last     <= load_row_last & ~later_nz;
            end
        end
    end

endmodule
